// File: rtl/nat_pkg.sv
// Shared NAT definitions: 5-tuple field offsets, key/tuple widths, default
// miss/collision conn ids, lookup FSM state encoding and the key fold helper.
package nat_pkg;

  localparam int TUPLE_W = 128;
  localparam int KEY_W   = 104;

  // Field LSB positions inside a 128-bit request tuple; [23:0] is ignored.
  localparam int SRC_IP_LSB   = 96;
  localparam int DST_IP_LSB   = 64;
  localparam int SRC_PORT_LSB = 48;
  localparam int DST_PORT_LSB = 32;
  localparam int PROTO_LSB    = 24;

  localparam logic [15:0] MISS_ID_DEF = 16'hFFFF;
  localparam logic [15:0] COLL_ID_DEF = 16'hFFFE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } nat_state_e;

  // XOR of the 13 key bytes; callers truncate to the index width.
  function automatic logic [7:0] key_fold(input logic [KEY_W-1:0] key);
    logic [7:0] acc;
    acc = 8'h00;
    for (int b = 0; b < KEY_W / 8; b++) begin
      acc = acc ^ key[b*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/nat_tuple_hash.sv
// Combinational normalise-and-hash of one request tuple.
// Ports:
//   tuple_i  128-bit request tuple
//   swap_i   1 = rx direction: swap src/dst ip and src/dst port
//   key_o    104-bit normalised key {src ip, dst ip, src port, dst port, proto}
//   idx_o    table index (byte-XOR of the key, truncated)
module nat_tuple_hash
  import nat_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic [TUPLE_W-1:0] tuple_i,
  input  logic               swap_i,
  output logic [KEY_W-1:0]   key_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [31:0]      src_ip_s;
  logic [31:0]      dst_ip_s;
  logic [15:0]      src_port_s;
  logic [15:0]      dst_port_s;
  logic [7:0]       proto_s;
  logic [KEY_W-1:0] key_s;
  logic [7:0]       fold_s;
  logic             unused_s;

  assign src_ip_s   = tuple_i[SRC_IP_LSB +: 32];
  assign dst_ip_s   = tuple_i[DST_IP_LSB +: 32];
  assign src_port_s = tuple_i[SRC_PORT_LSB +: 16];
  assign dst_port_s = tuple_i[DST_PORT_LSB +: 16];
  assign proto_s    = tuple_i[PROTO_LSB +: 8];
  assign unused_s   = ^tuple_i[PROTO_LSB-1:0];

  // Build the normalised key so both directions of a flow share one entry.
  always_comb begin
    if (swap_i) begin
      key_s = {dst_ip_s, src_ip_s, dst_port_s, src_port_s, proto_s};
    end else begin
      key_s = {src_ip_s, dst_ip_s, src_port_s, dst_port_s, proto_s};
    end
    fold_s = key_fold(key_s);
  end

  assign key_o = key_s;
  assign idx_o = fold_s[IDX_W-1:0];

endmodule

// File: rtl/nat_conn_table.sv
// NAT connection table: direct-mapped, DEPTH entries, two request ports.
// Port 0 (tx) inserts on miss, port 1 (rx) only looks up.
// Ports:
//   clk, reset                    clock, async active-low reset
//   tuple_data_x / tuple_valid_x  128-bit request tuple and one-cycle pulse
//   conn_data_x / conn_valid_x    16-bit conn id response and one-cycle pulse
//   entry_count                   number of valid entries
//   drop_count                    saturating count of requests dropped
//                                 because the port's pending slot was full
module nat_conn_table
  import nat_pkg::*;
#(
  parameter int          DEPTH   = 64,
  parameter logic [15:0] MISS_ID = MISS_ID_DEF,
  parameter logic [15:0] COLL_ID = COLL_ID_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TUPLE_W-1:0] tuple_data_0,
  input  logic               tuple_valid_0,
  output logic [15:0]        conn_data_0,
  output logic               conn_valid_0,
  input  logic [TUPLE_W-1:0] tuple_data_1,
  input  logic               tuple_valid_1,
  output logic [15:0]        conn_data_1,
  output logic               conn_valid_1,
  output logic [8:0]         entry_count,
  output logic [7:0]         drop_count
);

  localparam int IDX_W = $clog2(DEPTH);

  nat_state_e         state_q, state_d;
  logic               pend0_q, pend0_d, pend1_q, pend1_d;
  logic [TUPLE_W-1:0] pdata0_q, pdata0_d, pdata1_q, pdata1_d;
  logic               sel_q, sel_d;          // 0 = tx served, 1 = rx served
  logic [KEY_W-1:0]   key_q, key_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               rd_valid_q, rd_valid_d;
  logic [KEY_W-1:0]   rd_key_q, rd_key_d;
  logic [15:0]        resp_id_q, resp_id_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [8:0]         entry_count_q, entry_count_d;
  logic [7:0]         drop_count_q, drop_count_d;
  logic               conn_valid0_q, conn_valid0_d, conn_valid1_q, conn_valid1_d;
  logic [15:0]        conn_data0_q, conn_data0_d, conn_data1_q, conn_data1_d;
  logic [KEY_W-1:0]   key_mem [DEPTH];

  logic               clr0_s, clr1_s, drop0_s, drop1_s;
  logic [8:0]         drop_sum_s;
  logic [TUPLE_W-1:0] hash_tuple_s;
  logic               hash_swap_s;
  logic [KEY_W-1:0]   hash_key_s;
  logic [IDX_W-1:0]   hash_idx_s;
  logic               hit_s;
  logic               wr_en_s;
  logic [15:0]        idx_id_s;

  // Hash whichever port IDLE would pick: tx has priority over rx.
  always_comb begin
    if (pend0_q) begin
      hash_tuple_s = pdata0_q;
      hash_swap_s  = 1'b0;
    end else begin
      hash_tuple_s = pdata1_q;
      hash_swap_s  = 1'b1;
    end
  end

  nat_tuple_hash #(.IDX_W(IDX_W)) u_hash (
    .tuple_i (hash_tuple_s),
    .swap_i  (hash_swap_s),
    .key_o   (hash_key_s),
    .idx_o   (hash_idx_s)
  );

  assign hit_s    = rd_valid_q && (rd_key_q == key_q);
  assign idx_id_s = {{(16-IDX_W){1'b0}}, idx_q};

  // Pending slots: a slot freed in RESP can accept a pulse on that same edge.
  always_comb begin
    clr0_s = (state_q == ST_RESP) && !sel_q;
    clr1_s = (state_q == ST_RESP) && sel_q;
    pdata0_d = pdata0_q;
    pdata1_d = pdata1_q;
    drop0_s  = 1'b0;
    drop1_s  = 1'b0;
    if (pend0_q && !clr0_s) begin
      pend0_d = 1'b1;
      drop0_s = tuple_valid_0;
    end else if (tuple_valid_0) begin
      pend0_d  = 1'b1;
      pdata0_d = tuple_data_0;
    end else begin
      pend0_d = 1'b0;
    end
    if (pend1_q && !clr1_s) begin
      pend1_d = 1'b1;
      drop1_s = tuple_valid_1;
    end else if (tuple_valid_1) begin
      pend1_d  = 1'b1;
      pdata1_d = tuple_data_1;
    end else begin
      pend1_d = 1'b0;
    end
    // Both ports may drop on the same edge, so add up to two and saturate.
    drop_sum_s = {1'b0, drop_count_q} + {8'd0, drop0_s} + {8'd0, drop1_s};
    if (drop_sum_s > 9'd255) begin
      drop_count_d = 8'hFF;
    end else begin
      drop_count_d = drop_sum_s[7:0];
    end
  end

  // Lookup FSM next state, table update and response generation.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    key_d         = key_q;
    idx_d         = idx_q;
    rd_valid_d    = rd_valid_q;
    rd_key_d      = rd_key_q;
    resp_id_d     = resp_id_q;
    valid_d       = valid_q;
    entry_count_d = entry_count_q;
    wr_en_s       = 1'b0;
    conn_valid0_d = 1'b0;
    conn_valid1_d = 1'b0;
    conn_data0_d  = conn_data0_q;
    conn_data1_d  = conn_data1_q;
    case (state_q)
      ST_IDLE: begin
        if (pend0_q || pend1_q) begin
          state_d = ST_READ;
          sel_d   = !pend0_q;
          key_d   = hash_key_s;
          idx_d   = hash_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        rd_valid_d = valid_q[idx_q];
        rd_key_d   = key_mem[idx_q];
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_RESP;
        if (hit_s) begin
          resp_id_d = idx_id_s;
        end else if (sel_q) begin
          resp_id_d = MISS_ID;
        end else if (!rd_valid_q) begin
          wr_en_s        = 1'b1;
          valid_d[idx_q] = 1'b1;
          entry_count_d  = entry_count_q + 9'd1;
          resp_id_d      = idx_id_s;
        end else begin
          resp_id_d = COLL_ID;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (sel_q) begin
          conn_valid1_d = 1'b1;
          conn_data1_d  = resp_id_q;
        end else begin
          conn_valid0_d = 1'b1;
          conn_data0_d  = resp_id_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pend0_q       <= 1'b0;
      pend1_q       <= 1'b0;
      pdata0_q      <= '0;
      pdata1_q      <= '0;
      sel_q         <= 1'b0;
      key_q         <= '0;
      idx_q         <= '0;
      rd_valid_q    <= 1'b0;
      rd_key_q      <= '0;
      resp_id_q     <= 16'h0000;
      valid_q       <= '0;
      entry_count_q <= 9'd0;
      drop_count_q  <= 8'd0;
      conn_valid0_q <= 1'b0;
      conn_valid1_q <= 1'b0;
      conn_data0_q  <= 16'h0000;
      conn_data1_q  <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pend0_q       <= pend0_d;
      pend1_q       <= pend1_d;
      pdata0_q      <= pdata0_d;
      pdata1_q      <= pdata1_d;
      sel_q         <= sel_d;
      key_q         <= key_d;
      idx_q         <= idx_d;
      rd_valid_q    <= rd_valid_d;
      rd_key_q      <= rd_key_d;
      resp_id_q     <= resp_id_d;
      valid_q       <= valid_d;
      entry_count_q <= entry_count_d;
      drop_count_q  <= drop_count_d;
      conn_valid0_q <= conn_valid0_d;
      conn_valid1_q <= conn_valid1_d;
      conn_data0_q  <= conn_data0_d;
      conn_data1_q  <= conn_data1_d;
    end
  end

  // Key storage carries no reset; entries are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      key_mem[idx_q] <= key_q;
    end
  end

  assign conn_data_0  = conn_data0_q;
  assign conn_valid_0 = conn_valid0_q;
  assign conn_data_1  = conn_data1_q;
  assign conn_valid_1 = conn_valid1_q;
  assign entry_count  = entry_count_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_nat_conn_table.sv
// Directed self-checking bench for nat_conn_table with a per-port
// expected-response queue holding conn id and due cycle.
module tb_nat_conn_table;

  logic         clk;
  logic         reset;
  logic [127:0] tuple_data_0, tuple_data_1;
  logic         tuple_valid_0, tuple_valid_1;
  logic [15:0]  conn_data_0, conn_data_1;
  logic         conn_valid_0, conn_valid_1;
  logic [8:0]   entry_count;
  logic [7:0]   drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;

  typedef struct {
    logic [15:0] id;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [15:0] last0 = 16'h0000;
  logic [15:0] last1 = 16'h0000;

  // 10.0.0.1:1234 -> 8.8.8.8:53 udp; key bytes XOR to 8'hF9 -> index 6'h39
  localparam logic [127:0] TA    = {32'h0A000001, 32'h08080808, 16'd1234, 16'd53, 8'd17, 24'h000000};
  localparam logic [127:0] TA_RX = {32'h08080808, 32'h0A000001, 16'd53, 16'd1234, 8'd17, 24'h123456};
  // Same XOR as TA (src ip and src port both differ by 8'h03), different key
  localparam logic [127:0] TC    = {32'h0A000002, 32'h08080808, 16'h04D1, 16'd53, 8'd17, 24'h000000};
  // 192.168.1.1:5000 -> 1.1.1.1:443 tcp; XOR 8'h4F -> index 6'h0F
  localparam logic [127:0] TB    = {32'hC0A80101, 32'h01010101, 16'd5000, 16'd443, 8'd6, 24'h000000};
  localparam logic [127:0] TB_RX = {32'h01010101, 32'hC0A80101, 16'd443, 16'd5000, 8'd6, 24'hABCDEF};
  localparam logic [127:0] TU    = {32'h01020304, 32'h05060708, 16'd80, 16'd443, 8'd6, 24'h000000};

  nat_conn_table dut (
    .clk          (clk),
    .reset        (reset),
    .tuple_data_0 (tuple_data_0),
    .tuple_valid_0(tuple_valid_0),
    .conn_data_0  (conn_data_0),
    .conn_valid_0 (conn_valid_0),
    .tuple_data_1 (tuple_data_1),
    .tuple_valid_1(tuple_valid_1),
    .conn_data_1  (conn_data_1),
    .conn_valid_1 (conn_valid_1),
    .entry_count  (entry_count),
    .drop_count   (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive both ports for the next rising edge (called at a falling edge).
  task automatic drive(input logic v0, input logic [127:0] d0, input logic v1, input logic [127:0] d1);
    @(negedge clk);
    tuple_valid_0 = v0;
    tuple_data_0  = d0;
    tuple_valid_1 = v1;
    tuple_data_1  = d1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 128'h0, 1'b0, 128'h0);
  endtask

  // Expected response after edge E0+lat, E0 being the edge sampling the pulse just driven.
  task automatic expect0(input logic [15:0] id, input int lat);
    exp_t e;
    e.id  = id;
    e.due = cyc_n + 1 + lat;
    q0.push_back(e);
  endtask

  task automatic expect1(input logic [15:0] id, input int lat);
    exp_t e;
    e.id  = id;
    e.due = cyc_n + 1 + lat;
    q1.push_back(e);
  endtask

  initial begin
    reset         = 1'b0;
    tuple_valid_0 = 1'b0;
    tuple_valid_1 = 1'b0;
    tuple_data_0  = 128'h0;
    tuple_data_1  = 128'h0;
    repeat (3) @(negedge clk);
    chk("rst_cv0", {31'd0, conn_valid_0}, 32'd0);
    chk("rst_cv1", {31'd0, conn_valid_1}, 32'd0);
    chk("rst_cd0", {16'd0, conn_data_0}, 32'd0);
    chk("rst_cd1", {16'd0, conn_data_1}, 32'd0);
    chk("rst_entries", {23'd0, entry_count}, 32'd0);
    chk("rst_drops", {24'd0, drop_count}, 32'd0);
    reset = 1'b1;

    // Response monitor: order, id, exact cycle, hold value, mutual exclusion.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (reset) begin
          if (conn_valid_0 || conn_valid_1)
            chk("both_valid", {31'd0, conn_valid_0 & conn_valid_1}, 32'd0);
          if (conn_valid_0) begin
            n_checks++;
            assert (q0.size() != 0) else begin
              n_errors++;
              $error("FAIL tx_unexpected: observed response %0h expected none", conn_data_0);
            end
            if (q0.size() != 0) begin
              e = q0.pop_front();
              chk("tx_id", {16'd0, conn_data_0}, {16'd0, e.id});
              chk("tx_cycle", cyc_n, e.due);
              last0 = e.id;
            end
          end else begin
            chk("tx_hold", {16'd0, conn_data_0}, {16'd0, last0});
          end
          if (conn_valid_1) begin
            n_checks++;
            assert (q1.size() != 0) else begin
              n_errors++;
              $error("FAIL rx_unexpected: observed response %0h expected none", conn_data_1);
            end
            if (q1.size() != 0) begin
              e = q1.pop_front();
              chk("rx_id", {16'd0, conn_data_1}, {16'd0, e.id});
              chk("rx_cycle", cyc_n, e.due);
              last1 = e.id;
            end
          end else begin
            chk("rx_hold", {16'd0, conn_data_1}, {16'd0, last1});
          end
          if (q0.size() != 0 && q0[0].due < cyc_n) begin
            chk("tx_timeout", cyc_n, q0[0].due);
            void'(q0.pop_front());
          end
          if (q1.size() != 0 && q1[0].due < cyc_n) begin
            chk("rx_timeout", cyc_n, q1[0].due);
            void'(q1.pop_front());
          end
        end
      end
    join_none

    // Reset during CHECK of a tx miss: no response, no insert.
    drive(1'b1, TA, 1'b0, 128'h0);
    idle(1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_cv0", {31'd0, conn_valid_0}, 32'd0);
    chk("abort_entries", {23'd0, entry_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(8);
    chk("abort_entries_after", {23'd0, entry_count}, 32'd0);

    // Tx insert, then tx hit.
    drive(1'b1, TA, 1'b0, 128'h0);
    expect0(16'h0039, 4);
    idle(8);
    chk("insert_entries", {23'd0, entry_count}, 32'd1);
    drive(1'b1, TA, 1'b0, 128'h0);
    expect0(16'h0039, 4);
    idle(8);
    chk("hit_entries", {23'd0, entry_count}, 32'd1);

    // Rx hit on the reverse direction, rx miss on an unknown flow.
    drive(1'b0, 128'h0, 1'b1, TA_RX);
    expect1(16'h0039, 4);
    idle(8);
    drive(1'b0, 128'h0, 1'b1, TU);
    expect1(16'hFFFF, 4);
    idle(8);

    // Collision on an occupied slot.
    drive(1'b1, TC, 1'b0, 128'h0);
    expect0(16'hFFFE, 4);
    idle(8);
    chk("coll_entries", {23'd0, entry_count}, 32'd1);

    // Simultaneous tx/rx: tx inserts first, rx then hits the new entry.
    drive(1'b1, TB, 1'b1, TB_RX);
    expect0(16'h000F, 4);
    expect1(16'h000F, 8);
    idle(12);
    chk("both_entries", {23'd0, entry_count}, 32'd2);

    // Three back-to-back tx pulses: one served, two dropped.
    drive(1'b1, TA, 1'b0, 128'h0);
    expect0(16'h0039, 4);
    drive(1'b1, TA, 1'b0, 128'h0);
    drive(1'b1, TA, 1'b0, 128'h0);
    idle(8);
    chk("drop_two", {24'd0, drop_count}, 32'd2);

    // A pulse in the RESP cycle of the same port is accepted.
    drive(1'b1, TA, 1'b0, 128'h0);
    expect0(16'h0039, 4);
    idle(3);
    drive(1'b1, TA, 1'b0, 128'h0);
    expect0(16'h0039, 4);
    idle(10);
    chk("resp_accept_drops", {24'd0, drop_count}, 32'd2);

    // Continuous tx pulses: one accepted every 4 cycles, 300 drops saturate.
    for (int i = 0; i < 400; i++) begin
      drive(1'b1, TA, 1'b0, 128'h0);
      if (i == 80) chk("drop_mid", {24'd0, drop_count}, 32'd62);
      if (i % 4 == 0) expect0(16'h0039, 4);
    end
    idle(10);
    chk("drop_sat", {24'd0, drop_count}, 32'd255);
    chk("final_entries", {23'd0, entry_count}, 32'd2);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
